hbridge_deadtime: RTL and testbench

//  Downstream of the PWM generator. Converts its single coe_PWM_out stream into four
//  H-bridge gate drives (A/B legs, high/low side) for the lidar spin motor.

---
 rtl/hbridge_deadtime.sv | 183 ++++++++++++++++++
 tb/tb_hbridge_deadtime.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbridge_deadtime.sv
// H-bridge gate driver: turns one PWM stream into four gate drives with
// programmable dead time, direction and brake, configured over Avalon-MM.
module hbridge_deadtime #(
  parameter int DT_WIDTH = 16,
  parameter int DT_RESET = 50
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  input  logic        pwm_in,
  output logic        coe_a_hi,
  output logic        coe_a_lo,
  output logic        coe_b_hi,
  output logic        coe_b_lo
);

  typedef enum logic [1:0] {
    S_OFF = 2'd0,
    S_ON  = 2'd1,
    S_REC = 2'd2,
    S_DT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_DT     = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;

  logic [DT_WIDTH-1:0] deadtime;
  logic                ctrl_en;
  logic                ctrl_dir;
  logic                ctrl_brake;

  state_t              state;
  state_t              state_next;
  state_t              target;
  logic [DT_WIDTH-1:0] cnt;
  logic [DT_WIDTH-1:0] cnt_next;
  logic                dir_q;
  logic                dir_next;

  logic a_hi_d, a_lo_d, b_hi_d, b_lo_d;

  logic unused_bits;
  assign unused_bits = ^{writedata, byteenable};

  function automatic logic [DT_WIDTH-1:0] merge_dt(
    input logic [DT_WIDTH-1:0] old,
    input logic [31:0]         wd,
    input logic [3:0]          be
  );
    logic [DT_WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < DT_WIDTH; i++) begin
      if (be[i/8]) r[i] = wd[i];
    end
    return r;
  endfunction

  // A zero dead time still forces one all-off cycle on every transition.
  function automatic logic [DT_WIDTH-1:0] dt_load(input logic [DT_WIDTH-1:0] d);
    return (d == '0) ? DT_WIDTH'(1) : d;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deadtime   <= DT_WIDTH'(DT_RESET);
      ctrl_en    <= 1'b0;
      ctrl_dir   <= 1'b0;
      ctrl_brake <= 1'b0;
    end else if (chipselect && write) begin
      if (address == ADDR_DT) deadtime <= merge_dt(deadtime, writedata, byteenable);
      if (address == ADDR_CTRL && byteenable[0]) begin
        ctrl_en    <= writedata[0];
        ctrl_dir   <= writedata[1];
        ctrl_brake <= writedata[2];
      end
    end
  end

  always_comb begin
    readdata = '0;
    if (read && chipselect) begin
      case (address)
        ADDR_DT:     readdata = 32'(deadtime);
        ADDR_CTRL:   readdata = {29'b0, ctrl_brake, ctrl_dir, ctrl_en};
        ADDR_STATUS: readdata = {23'b0, dir_q, 5'b0, 1'b0, state};
        default:     readdata = '0;
      endcase
    end
  end

  always_comb begin
    if (!ctrl_en)       target = S_OFF;
    else if (ctrl_brake) target = S_REC;
    else if (pwm_in)    target = S_ON;
    else                target = S_REC;
  end

  // dir_q only moves at dead-time exit, so a reversal always sees all gates off.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    dir_next   = dir_q;
    case (state)
      S_OFF: begin
        if (target != S_OFF) begin
          state_next = S_DT;
          cnt_next   = dt_load(deadtime);
        end
      end
      S_ON, S_REC: begin
        if (!ctrl_en) begin
          state_next = S_OFF;
        end else if (target != state || ctrl_dir != dir_q) begin
          state_next = S_DT;
          cnt_next   = dt_load(deadtime);
        end
      end
      S_DT: begin
        if (!ctrl_en) begin
          state_next = S_OFF;
        end else if (cnt <= DT_WIDTH'(1)) begin
          state_next = target;
          dir_next   = ctrl_dir;
        end else begin
          cnt_next = cnt - DT_WIDTH'(1);
        end
      end
      default: state_next = S_OFF;
    endcase
  end

  always_comb begin
    a_hi_d = 1'b0;
    a_lo_d = 1'b0;
    b_hi_d = 1'b0;
    b_lo_d = 1'b0;
    case (state_next)
      S_ON: begin
        if (dir_next) begin
          b_hi_d = 1'b1;
          a_lo_d = 1'b1;
        end else begin
          a_hi_d = 1'b1;
          b_lo_d = 1'b1;
        end
      end
      S_REC: begin
        a_lo_d = 1'b1;
        b_lo_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Gates are decoded from the next state so they change with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_OFF;
      cnt      <= '0;
      dir_q    <= 1'b0;
      coe_a_hi <= 1'b0;
      coe_a_lo <= 1'b0;
      coe_b_hi <= 1'b0;
      coe_b_lo <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      dir_q    <= dir_next;
      coe_a_hi <= a_hi_d;
      coe_a_lo <= a_lo_d;
      coe_b_hi <= b_hi_d;
      coe_b_lo <= b_lo_d;
    end
  end

endmodule

// File: tb/tb_hbridge_deadtime.sv
// Bench for hbridge_deadtime: register table, dead-time corner sequences and
// a randomized run against a mode/gap reference model.
module tb_hbridge_deadtime;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [3:0]  byteenable = 4'd0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        pwm_in = 1'b0;
  logic        coe_a_hi, coe_a_lo, coe_b_hi, coe_b_lo;

  int tests = 0;
  int fails = 0;

  hbridge_deadtime dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .address(address),
    .write(write), .writedata(writedata), .byteenable(byteenable), .read(read),
    .readdata(readdata), .pwm_in(pwm_in), .coe_a_hi(coe_a_hi), .coe_a_lo(coe_a_lo),
    .coe_b_hi(coe_b_hi), .coe_b_lo(coe_b_lo)
  );

  always #5 clk = ~clk;

  // Reference model: drive mode (0 off, 1 on, 2 recirculate), remaining gap
  // cycles of all-off, and the direction the bridge is actually driving.
  int          m_mode;
  int          m_gap;
  logic        m_dir;
  logic [15:0] m_dt;
  logic        m_en, m_dirc, m_brake;

  localparam logic [3:0] G_OFF  = 4'b0000;
  localparam logic [3:0] G_ON0  = 4'b1001;
  localparam logic [3:0] G_ON1  = 4'b0110;
  localparam logic [3:0] G_REC  = 4'b0101;

  function automatic logic [3:0] gates();
    return {coe_a_hi, coe_a_lo, coe_b_hi, coe_b_lo};
  endfunction

  function automatic logic [3:0] exp_gates();
    if (m_gap > 0 || m_mode == 0) return G_OFF;
    if (m_mode == 1) return m_dir ? G_ON1 : G_ON0;
    return G_REC;
  endfunction

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    case (a)
      2'd0: return {16'd0, m_dt};
      2'd1: return {29'd0, m_brake, m_dirc, m_en};
      2'd2: return {23'd0, m_dir, 5'd0, 3'((m_gap > 0) ? 3 : m_mode)};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_gap = 0; m_dir = 1'b0;
    m_dt = 16'd50; m_en = 1'b0; m_dirc = 1'b0; m_brake = 1'b0;
  endtask

  task automatic model_step();
    int tgt;
    int d;
    if (!reset_n) begin
      model_reset();
      return;
    end
    tgt = !m_en ? 0 : (m_brake ? 2 : (pwm_in ? 1 : 2));
    d   = (m_dt == 16'd0) ? 1 : int'(m_dt);
    if (m_gap > 0) begin
      if (!m_en) begin
        m_gap = 0; m_mode = 0;
      end else if (m_gap == 1) begin
        m_gap = 0; m_mode = tgt; m_dir = m_dirc;
      end else begin
        m_gap--;
      end
    end else if (m_mode == 0) begin
      if (m_en) m_gap = d;
    end else if (!m_en) begin
      m_mode = 0;
    end else if (tgt != m_mode || m_dirc != m_dir) begin
      m_gap = d;
    end
    if (chipselect && write) begin
      if (address == 2'd0) begin
        for (int b = 0; b < 2; b++)
          if (byteenable[b]) m_dt[8*b +: 8] = writedata[8*b +: 8];
      end else if (address == 2'd1 && byteenable[0]) begin
        m_en = writedata[0]; m_dirc = writedata[1]; m_brake = writedata[2];
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic [3:0] g;
    @(posedge clk);
    model_step();
    @(negedge clk);
    g = gates();
    check("gates_vs_model", 32'(g), 32'(exp_gates()));
    tests++;
    if ((g[3] & g[2]) | (g[1] & g[0]) | (g[3] & g[1])) begin
      fails++;
      $display("FAIL shoot_through: gates %b at %0t", g, $time);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] be);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d; byteenable = be;
    tick();
    chipselect = 1'b0; write = 1'b0; byteenable = 4'd0;
  endtask

  task automatic read_check(input string name, input logic cs, input logic [1:0] a,
                            input logic [31:0] exp);
    chipselect = cs; read = 1'b1; address = a;
    #1;
    check(name, readdata, exp);
    read = 1'b0; chipselect = 1'b0;
  endtask

  task automatic measure(output int zeros, output logic [3:0] g);
    zeros = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (gates() != G_OFF) break;
      zeros++;
    end
    g = gates();
  endtask

  task automatic expect_gap(input string name, input int zexp, input logic [3:0] gexp);
    int z;
    logic [3:0] g;
    measure(z, g);
    check({name, "_zeros"}, 32'(z), 32'(zexp));
    check({name, "_gates"}, 32'(g), 32'(gexp));
  endtask

  typedef struct {
    string       name;
    logic        cs;
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    int z;
    logic [3:0] g;
    logic on_seen;
    int r;

    vecs[0]  = '{"dt_reset",     1'b1, 1'b0, 2'd0, 32'h0,          4'h0, 32'd50};
    vecs[1]  = '{"ctrl_reset",   1'b1, 1'b0, 2'd1, 32'h0,          4'h0, 32'd0};
    vecs[2]  = '{"status_reset", 1'b1, 1'b0, 2'd2, 32'h0,          4'h0, 32'd0};
    vecs[3]  = '{"addr3_reset",  1'b1, 1'b0, 2'd3, 32'h0,          4'h0, 32'd0};
    vecs[4]  = '{"no_chipsel",   1'b0, 1'b0, 2'd0, 32'h0,          4'h0, 32'd0};
    vecs[5]  = '{"dt_byte0",     1'b1, 1'b1, 2'd0, 32'h1234_ABCD, 4'h1, 32'h0000_00CD};
    vecs[6]  = '{"dt_byte1",     1'b1, 1'b1, 2'd0, 32'h0000_7700, 4'h2, 32'h0000_77CD};
    vecs[7]  = '{"dt_full",      1'b1, 1'b1, 2'd0, 32'hFFFF_000A, 4'hF, 32'h0000_000A};
    vecs[8]  = '{"ctrl_be_none", 1'b1, 1'b1, 2'd1, 32'h0000_00FF, 4'h0, 32'd0};
    vecs[9]  = '{"ctrl_dirbrk",  1'b1, 1'b1, 2'd1, 32'hFFFF_FFF6, 4'h1, 32'd6};
    vecs[10] = '{"status_ro",    1'b1, 1'b1, 2'd2, 32'hFFFF_FFFF, 4'hF, 32'd0};
    vecs[11] = '{"addr3_ro",     1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 4'hF, 32'd0};
    vecs[12] = '{"ctrl_clear",   1'b1, 1'b1, 2'd1, 32'h0,          4'h1, 32'd0};

    model_reset();
    repeat (3) tick();
    check("reset_gates", 32'(gates()), 32'(G_OFF));
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata, vecs[i].be);
      read_check(vecs[i].name, vecs[i].cs, vecs[i].addr, vecs[i].rexp);
    end

    // DEADTIME is 10 here; enable with dir 0 and walk through the transitions.
    bus_write(2'd1, 32'd1, 4'h1);
    expect_gap("off_to_rec", 10, G_REC);
    pwm_in = 1'b1;
    expect_gap("pwm_rise", 10, G_ON0);
    pwm_in = 1'b0;
    expect_gap("pwm_fall", 10, G_REC);
    pwm_in = 1'b1;
    expect_gap("pwm_rise2", 10, G_ON0);
    bus_write(2'd1, 32'd3, 4'h1);
    expect_gap("dir_reverse", 10, G_ON1);
    read_check("status_dir1_on", 1'b1, 2'd2, 32'h0000_0101);

    // Narrow pulse: never reaches ON, one D-long gap then back to REC.
    pwm_in = 1'b0;
    expect_gap("pre_pulse", 10, G_REC);
    pwm_in = 1'b1;
    z = 0;
    on_seen = 1'b0;
    repeat (3) begin
      tick();
      if (gates() == G_OFF) z++;
      if (gates() == G_ON0 || gates() == G_ON1) on_seen = 1'b1;
    end
    pwm_in = 1'b0;
    measure(r, g);
    check("pulse_zeros", 32'(z + r), 32'd10);
    check("pulse_gates", 32'(g), 32'(G_REC));
    check("pulse_never_on", 32'(on_seen), 32'd0);

    bus_write(2'd0, 32'd0, 4'hF);
    pwm_in = 1'b1;
    expect_gap("dt0_rise", 1, G_ON1);
    pwm_in = 1'b0;
    expect_gap("dt0_fall", 1, G_REC);

    bus_write(2'd0, 32'd10, 4'hF);
    pwm_in = 1'b1;
    expect_gap("rise_before_brake", 10, G_ON1);
    bus_write(2'd1, 32'd7, 4'h1);
    expect_gap("brake", 10, G_REC);

    bus_write(2'd1, 32'd3, 4'h1);
    expect_gap("unbrake", 10, G_ON1);
    bus_write(2'd1, 32'd0, 4'h1);
    check("disable_write_cycle", 32'(gates()), 32'(G_ON1));
    tick();
    check("disable_mid_on", 32'(gates()), 32'(G_OFF));
    read_check("status_off", 1'b1, 2'd2, 32'h0000_0100);

    bus_write(2'd1, 32'd3, 4'h1);
    repeat (4) tick();
    read_check("status_in_dt", 1'b1, 2'd2, 32'h0000_0103);
    bus_write(2'd1, 32'd0, 4'h1);
    tick();
    read_check("disable_mid_dt", 1'b1, 2'd2, 32'h0000_0100);

    bus_write(2'd1, 32'd1, 4'h1);
    expect_gap("reenable_dir0", 10, G_ON0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_gates", 32'(gates()), 32'(G_OFF));
    read_check("async_reset_dt", 1'b1, 2'd0, 32'd50);
    tick();
    reset_n = 1'b1;
    tick();
    check("post_reset_gates", 32'(gates()), 32'(G_OFF));
    read_check("post_reset_status", 1'b1, 2'd2, 32'd0);

    // Randomized run against the model.
    bus_write(2'd0, 32'd3, 4'hF);
    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 30) pwm_in = ~pwm_in;
      if (r < 6)
        bus_write(2'd1, {29'd0, ($urandom_range(0, 4) == 0), 1'($urandom),
                         ($urandom_range(0, 9) != 0)}, 4'h1);
      else if (r < 8)
        bus_write(2'd0, 32'($urandom_range(0, 6)), 4'hF);
      else if (r < 9)
        bus_write(2'($urandom_range(2, 3)), $urandom, 4'($urandom));
      else
        tick();
      if (r % 10 == 0) begin
        address = 2'($urandom_range(0, 3));
        read_check("rand_read", 1'b1, address, exp_read(address));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
